// File: rtl/pps_period_counter.sv
// Measures the cycle distance between PPS rising edges, with glitch rejection,
// loss detection and a valid/ack result handshake.
//   state   | meaning
//   IDLE    | after reset, waiting for the first edge to start a measurement
//   MEASURE | locked, counting cycles since the last accepted edge
//   LOST    | no edge within TIMEOUT cycles, counter frozen
module pps_period_counter #(
  parameter int CNT_W      = 32,
  parameter int NOMINAL    = 120000000,
  parameter int MIN_PERIOD = 108000000,
  parameter int TIMEOUT    = 132000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pps_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] deviation,
  output logic             period_valid,
  input  logic             period_ack,
  output logic             overrun,
  output logic             glitch,
  output logic             pps_lost,
  output logic             locked
);

  typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_e;

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0] NOM_C = CNT_W'(NOMINAL);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q, deviation_q;
  logic             valid_q, overrun_q, glitch_q, pps_lost_q, locked_q;

  logic             pps_edge;
  logic [CNT_W-1:0] n_d;
  logic             capture;

  assign pps_edge = s2_q & ~s3_q;
  // n_d is the cycle distance to the last accepted edge if an edge lands now
  assign n_d      = cnt_q + ONE_C;
  assign capture  = (state_q == MEASURE) && pps_edge && (n_d >= MIN_C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      deviation_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      glitch_q    <= 1'b0;
      pps_lost_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      s1_q     <= pps_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      glitch_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pps_edge) begin
            cnt_q    <= '0;
            state_q  <= MEASURE;
            locked_q <= 1'b1;
          end
        end
        MEASURE: begin
          // an edge coinciding with the timeout wins over the loss transition
          if (pps_edge) begin
            if (n_d >= MIN_C) begin
              cnt_q <= '0;
            end else begin
              cnt_q    <= n_d;
              glitch_q <= 1'b1;
            end
          end else if (n_d == TMO_C) begin
            state_q    <= LOST;
            locked_q   <= 1'b0;
            pps_lost_q <= 1'b1;
          end else begin
            cnt_q <= n_d;
          end
        end
        LOST: begin
          if (pps_edge) begin
            cnt_q      <= '0;
            state_q    <= MEASURE;
            pps_lost_q <= 1'b0;
            locked_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          locked_q   <= 1'b0;
          pps_lost_q <= 1'b0;
        end
      endcase

      if (capture) begin
        period_q    <= n_d;
        deviation_q <= n_d - NOM_C;
        valid_q     <= 1'b1;
        if (valid_q && !period_ack) overrun_q <= 1'b1;
      end else if (period_ack && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign period       = period_q;
  assign deviation    = deviation_q;
  assign period_valid = valid_q;
  assign overrun      = overrun_q;
  assign glitch       = glitch_q;
  assign pps_lost     = pps_lost_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_pps_period_counter.sv
// Bench for pps_period_counter: directed scenarios then random pulse trains,
// compared every cycle against an edge-time based reference model.
module tb_pps_period_counter;

  localparam int CNT_W = 16;
  localparam int NOM   = 100;
  localparam int MINP  = 90;
  localparam int TMO   = 110;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pps_in = 1'b0;
  logic             period_ack = 1'b0;
  logic [CNT_W-1:0] period, deviation;
  logic             period_valid, overrun, glitch, pps_lost, locked;

  pps_period_counter #(
    .CNT_W(CNT_W), .NOMINAL(NOM), .MIN_PERIOD(MINP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pps_in(pps_in),
    .period(period), .deviation(deviation), .period_valid(period_valid),
    .period_ack(period_ack), .overrun(overrun), .glitch(glitch),
    .pps_lost(pps_lost), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 measuring, 2 lost; last_t = clock index of last restart
  int               t = 0;
  int               mode = 0;
  int               last_t = 0;
  bit               prev_s = 1'b0;
  int               pend[$];
  logic [CNT_W-1:0] m_period = '0, m_dev = '0;
  bit               m_valid = 0, m_ovr = 0, m_glitch = 0;
  int               ack_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit e;
    int n;
    if (ack_mode == 1) period_ack = m_valid;
    else if (ack_mode == 2) period_ack = ($urandom_range(0, 3) == 0);
    if (!rst_n) begin
      mode = 0; last_t = 0; prev_s = 1'b0; pend.delete();
      m_period = '0; m_dev = '0; m_valid = 0; m_ovr = 0; m_glitch = 0;
    end else begin
      e = 0;
      if (pend.size() > 0 && pend[0] == t) begin
        e = 1;
        void'(pend.pop_front());
      end
      // a rise first seen at clock t takes effect at clock t+2
      if (pps_in && !prev_s) pend.push_back(t + 2);
      prev_s = pps_in;
      m_glitch = 0;
      n = t - last_t;
      if (mode == 1 && e && n >= MINP) begin
        if (m_valid && !period_ack) m_ovr = 1;
        m_valid  = 1;
        m_period = CNT_W'(n);
        m_dev    = CNT_W'(n - NOM);
      end else if (period_ack && m_valid) begin
        m_valid = 0;
        m_ovr   = 0;
      end
      if (e) begin
        if (mode == 1 && n < MINP) m_glitch = 1;
        else begin
          mode   = 1;
          last_t = t;
        end
      end else if (mode == 1 && n == TMO) begin
        mode = 2;
      end
    end
    t++;
    @(posedge clk);
    #1;
    chk("period", period, m_period);
    chk("deviation", deviation, m_dev);
    chk("period_valid", period_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("glitch", glitch, m_glitch);
    chk("pps_lost", pps_lost, mode == 2);
    chk("locked", locked, mode == 1);
  endtask

  task automatic pulse(input int gap);
    pps_in = 1'b1; step(); pps_in = 1'b0;
    repeat (gap - 1) step();
  endtask

  // rise now, check the capture ending the previous gap, then fill to gap cycles
  task automatic pulse_chk(input int gap, input int expp);
    logic [CNT_W-1:0] ed;
    ed = CNT_W'(expp - NOM);
    pps_in = 1'b1; step(); pps_in = 1'b0;
    step(); step();
    chk("cap_valid", period_valid, 1);
    chk("cap_period", period, expp);
    chk("cap_deviation", deviation, ed);
    repeat (gap - 3) step();
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_valid", period_valid, 0);
    chk("reset_locked", locked, 0);
    rst_n = 1'b1;
    step();

    // first edge only starts the measurement
    pps_in = 1'b1; step(); pps_in = 1'b0;
    step(); step();
    chk("first_edge_novalid", period_valid, 0);
    chk("first_edge_locked", locked, 1);
    repeat (97) step();
    pulse_chk(100, 100);
    chk("locked_after_capture", locked, 1);

    ack_mode = 1;
    pulse_chk(103, 100);
    pulse_chk(97, 103);

    // glitch 40 cycles after a good edge
    pps_in = 1'b1; step(); pps_in = 1'b0;
    step(); step();
    chk("cap97_period", period, 97);
    chk("cap97_dev", deviation, 16'hFFFD);
    chk("cap97_overrun", overrun, 0);
    repeat (37) step();
    pps_in = 1'b1; step(); pps_in = 1'b0;
    step(); step();
    chk("glitch_pulse", glitch, 1);
    step();
    chk("glitch_one_cycle", glitch, 0);
    repeat (56) step();
    pulse_chk(100, 100);

    // loss after 110 cycles without an edge, then re-acquisition
    pps_in = 1'b1; step(); pps_in = 1'b0;
    repeat (111) step();
    chk("lost_not_yet", pps_lost, 0);
    chk("locked_not_yet", locked, 1);
    step();
    chk("lost_at_timeout", pps_lost, 1);
    chk("unlocked_at_timeout", locked, 0);
    repeat (30) step();
    chk("lost_held", pps_lost, 1);
    pps_in = 1'b1; step(); pps_in = 1'b0;
    step(); step();
    chk("resume_lost_clear", pps_lost, 0);
    chk("resume_locked", locked, 1);
    chk("resume_no_capture", period_valid, 0);
    repeat (97) step();
    pulse_chk(100, 100);

    // overrun and ack interactions
    ack_mode = 0;
    period_ack = 1'b0;
    pulse_chk(95, 100);
    pps_in = 1'b1; step(); pps_in = 1'b0;
    step(); step();
    chk("overrun_set", overrun, 1);
    chk("overrun_period", period, 95);
    period_ack = 1'b1; step(); period_ack = 1'b0;
    chk("ack_clears_valid", period_valid, 0);
    chk("ack_clears_overrun", overrun, 0);
    repeat (96) step();
    pulse_chk(104, 100);
    pps_in = 1'b1; step(); pps_in = 1'b0;
    step();
    period_ack = 1'b1; step(); period_ack = 1'b0;
    chk("ack_cap_valid", period_valid, 1);
    chk("ack_cap_overrun", overrun, 0);
    chk("ack_cap_period", period, 104);
    repeat (97) step();

    // reset mid-period
    pps_in = 1'b1; step(); pps_in = 1'b0;
    repeat (49) step();
    rst_n = 1'b0; step();
    chk("midrst_period", period, 0);
    chk("midrst_valid", period_valid, 0);
    chk("midrst_locked", locked, 0);
    rst_n = 1'b1;
    repeat (49) step();
    pps_in = 1'b1; step(); pps_in = 1'b0;
    step(); step();
    chk("post_rst_no_capture", period_valid, 0);
    chk("post_rst_locked", locked, 1);
    repeat (97) step();
    pulse_chk(100, 100);

    // random pulse trains and acks
    ack_mode = 2;
    for (int i = 0; i < 40; i++) begin
      pulse(int'($urandom_range(20, 140)));
    end
    repeat (150) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
